// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the byte-lane data memory.
// Size codes match the req_size port; states cover the clear sweep and normal operation.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int LANES = 4;

    // Reserved size or a lane offset that breaks natural alignment.
    function automatic logic size_lane_err(input size_e sz, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: store-side byte mask and data replication,
// load-side lane extraction with sign or zero extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    size_e       sz;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign sz = size_e'(size);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        byte_mask = 4'b0000;
        wdata_rep = 32'd0;
        case (sz)
            SZ_BYTE: begin
                byte_mask = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_mask = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_mask = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                byte_mask = 4'b0000;
                wdata_rep = 32'd0;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'd0;
        case (lane)
            2'd0:    ld_byte = raw_word[7:0];
            2'd1:    ld_byte = raw_word[15:8];
            2'd2:    ld_byte = raw_word[23:16];
            default: ld_byte = raw_word[31:24];
        endcase
    end

    assign ld_half = lane[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        rdata_ext = 32'd0;
        case (sz)
            SZ_BYTE: rdata_ext = sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
            SZ_HALF: rdata_ext = sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
            SZ_WORD: rdata_ext = raw_word;
            default: rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte/half/word data memory with a valid/ready request port, one-cycle registered
// response, alignment and range checking, and an optional post-reset clear sweep.
module data_memory_bytelane
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2     = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_e        state_q, state_d;
    logic [IW-1:0] clr_ptr_q, clr_ptr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem_q [DEPTH];

    logic [IW-1:0] word_idx;
    logic [1:0]    lane;
    logic          range_err;
    logic          req_err;
    logic          accept;

    logic [3:0]    st_mask;
    logic [31:0]   st_data;
    logic [31:0]   ld_data;
    logic [31:0]   raw_word;

    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [3:0]    mem_mask;
    logic [31:0]   mem_data;

    assign word_idx  = req_addr[IW+1:2];
    assign lane      = req_addr[1:0];
    assign range_err = (req_addr >> (IW + 2)) != 32'd0;
    assign req_err   = range_err | size_lane_err(size_e'(req_size), lane);

    // Ready depends only on state and reset so it never combinationally loops through req_valid.
    assign req_ready = (state_q == ST_RUN) && !rst;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q == ST_CLEAR);

    assign raw_word  = mem_q[word_idx];

    dm_lane_align u_align (
        .size      (req_size),
        .lane      (lane),
        .sign_ext  (req_signed),
        .wdata     (req_wdata),
        .raw_word  (raw_word),
        .byte_mask (st_mask),
        .wdata_rep (st_data),
        .rdata_ext (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == {IW{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    // The sweep and accepted stores share one write port; the sweep only runs while not ready.
    always_comb begin
        mem_we   = 1'b0;
        mem_idx  = word_idx;
        mem_mask = 4'b0000;
        mem_data = 32'd0;
        if (!rst && state_q == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_idx  = clr_ptr_q;
            mem_mask = 4'b1111;
        end else if (accept && req_we && !req_err) begin
            mem_we   = 1'b1;
            mem_mask = st_mask;
            mem_data = st_data;
        end
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept && req_err;
        rsp_rdata_d = 32'd0;
        if (accept && !req_we && !req_err) begin
            rsp_rdata_d = ld_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the array has no reset branch; zeroing it is the sweep's job, which keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (mem_mask[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_data[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench for data_memory_bytelane: clear sweep, lane loads/stores, errors,
// mid-stream reset, and retention with the sweep disabled.
module tb_data_memory_bytelane;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    logic        nc_rst;
    logic        nc_valid;
    logic        nc_ready;
    logic        nc_we;
    logic [1:0]  nc_size;
    logic        nc_signed;
    logic [31:0] nc_addr;
    logic [31:0] nc_wdata;
    logic        nc_rsp_valid;
    logic [31:0] nc_rsp_rdata;
    logic        nc_rsp_err;
    logic        nc_busy;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_bytelane #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    data_memory_bytelane #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk        (clk),
        .rst        (nc_rst),
        .req_valid  (nc_valid),
        .req_ready  (nc_ready),
        .req_we     (nc_we),
        .req_size   (nc_size),
        .req_signed (nc_signed),
        .req_addr   (nc_addr),
        .req_wdata  (nc_wdata),
        .rsp_valid  (nc_rsp_valid),
        .rsp_rdata  (nc_rsp_rdata),
        .rsp_err    (nc_rsp_err),
        .busy       (nc_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge; returns at the next negedge with its response visible.
    task automatic issue(input string tag, input logic we, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic err, input logic [31:0] rdata);
        check({tag, " valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, " err"},   {31'd0, rsp_err},   {31'd0, err});
        check({tag, " rdata"}, rsp_rdata, rdata);
    endtask

    task automatic expect_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            check({tag, " busy"},  {31'd0, busy},      32'd1);
            check({tag, " ready"}, {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        check({tag, " busy end"},  {31'd0, busy},      32'd0);
        check({tag, " ready end"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;  req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        nc_rst = 1'b1; nc_valid = 1'b0; nc_we = 1'b0; nc_size = 2'b00;
        nc_signed = 1'b0; nc_addr = 32'd0; nc_wdata = 32'd0;

        repeat (3) @(negedge clk);
        check("rst ready",     {31'd0, req_ready}, 32'd0);
        check("rst busy",      {31'd0, busy},      32'd1);
        check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata,          32'd0);
        check("rst rsp_err",   {31'd0, rsp_err},   32'd0);

        rst = 1'b0;
        nc_rst = 1'b0;
        #1;
        check("nc ready after rst", {31'd0, nc_ready}, 32'd1);
        check("nc busy after rst",  {31'd0, nc_busy},  32'd0);
        #1;
        expect_sweep("sweep1");

        issue("lw 3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'd0);
        expect_rsp("lw 3c", 1'b0, 32'h0000_0000);

        issue("sw 10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899_AABB);
        expect_rsp("sw 10", 1'b0, 32'h0000_0000);
        issue("lb 13", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
        expect_rsp("lb 13", 1'b0, 32'hFFFF_FF88);
        issue("lbu 13", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
        expect_rsp("lbu 13", 1'b0, 32'h0000_0088);
        issue("lh 10", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0);
        expect_rsp("lh 10", 1'b0, 32'hFFFF_AABB);
        issue("lhu 12", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
        expect_rsp("lhu 12", 1'b0, 32'h0000_8899);

        issue("sb 11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A);
        expect_rsp("sb 11", 1'b0, 32'h0);
        issue("lw 10 b2b", 1'b0, 2'b10, 1'b1, 32'h10, 32'd0);
        expect_rsp("lw 10 b2b", 1'b0, 32'h8899_5ABB);

        issue("sh 16", 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_BEEF);
        expect_rsp("sh 16", 1'b0, 32'h0);
        issue("lw 14", 1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
        expect_rsp("lw 14", 1'b0, 32'hBEEF_0000);
        issue("lh 16", 1'b0, 2'b01, 1'b1, 32'h16, 32'd0);
        expect_rsp("lh 16", 1'b0, 32'hFFFF_BEEF);

        issue("lw 12 misal", 1'b0, 2'b10, 1'b0, 32'h12, 32'd0);
        expect_rsp("lw 12 misal", 1'b1, 32'h0);
        issue("lh 13 misal", 1'b0, 2'b01, 1'b1, 32'h13, 32'd0);
        expect_rsp("lh 13 misal", 1'b1, 32'h0);
        issue("rsvd 10", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
        expect_rsp("rsvd 10", 1'b1, 32'h0);
        issue("lw 40 range", 1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        expect_rsp("lw 40 range", 1'b1, 32'h0);
        issue("sw 40 range", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
        expect_rsp("sw 40 range", 1'b1, 32'h0);
        issue("lw 00", 1'b0, 2'b10, 1'b0, 32'h00, 32'd0);
        expect_rsp("lw 00", 1'b0, 32'h0000_0000);

        @(negedge clk);
        check("idle rsp_valid", {31'd0, rsp_valid}, 32'd0);

        issue("lw 10 pre-rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        expect_rsp("lw 10 pre-rst", 1'b0, 32'h8899_5ABB);
        rst = 1'b1;
        req_valid = 1'b1;
        #1;
        check("mid rst ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("mid rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid rst busy",      {31'd0, busy},      32'd1);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        expect_sweep("sweep2");
        issue("lw 10 post", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        expect_rsp("lw 10 post", 1'b0, 32'h0000_0000);

        nc_valid = 1'b1; nc_we = 1'b1; nc_size = 2'b10; nc_addr = 32'h08; nc_wdata = 32'h1234_5678;
        @(negedge clk);
        nc_valid = 1'b0;
        check("nc sw valid", {31'd0, nc_rsp_valid}, 32'd1);
        check("nc sw err",   {31'd0, nc_rsp_err},   32'd0);
        nc_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("nc rst busy",      {31'd0, nc_busy},      32'd0);
        check("nc rst rsp_valid", {31'd0, nc_rsp_valid}, 32'd0);
        nc_rst = 1'b0;
        #1;
        check("nc ready post rst", {31'd0, nc_ready}, 32'd1);
        nc_valid = 1'b1; nc_we = 1'b0; nc_size = 2'b10; nc_addr = 32'h08;
        @(negedge clk);
        nc_valid = 1'b0;
        check("nc lw valid", {31'd0, nc_rsp_valid}, 32'd1);
        check("nc lw rdata", nc_rsp_rdata,          32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
